typing_checker: RTL

Consumer end of the keyboard parser's character stream. Takes decoded PS/2 set-2 scan-code bytes from the keyboard receiver and filters them down to single key presses. It compares each press against the expected `comparison_data` byte and pulses `get_next_character` on a match. It drives `enable_next_level` to start the game and to advance levels, and tracks character position, errors, level, and game-over.

---
 rtl/typer_pkg.sv | 20 ++
 rtl/ps2_make_filter.sv | 49 ++++
 rtl/typing_checker.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/typer_pkg.sv
// Shared scan-code constants, FSM encoding and helpers for the typing checker.
// Pure declarations; no logic, latency or flow control of its own.
package typer_pkg;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_PLAY   = 3'd2,
    ST_NEXT   = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/ps2_make_filter.sv
// Reduces raw PS/2 set-2 bytes to single non-extended key presses (break, E0 and repeat removal).
// press_valid is registered one cycle after key_valid; no backpressure, one byte per strobe.
module ps2_make_filter
  import typer_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic       key_valid,
  input  logic [7:0] key_code,
  output logic       press_valid,
  output logic [7:0] press_code
);

  logic       brk;
  logic       ext;
  logic [7:0] held;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      brk         <= 1'b0;
      ext         <= 1'b0;
      held        <= 8'h00;
      press_valid <= 1'b0;
      press_code  <= 8'h00;
    end else begin
      press_valid <= 1'b0;
      if (key_valid) begin
        if (key_code == SC_BREAK) begin
          brk <= 1'b1;
        end else if (key_code == SC_EXT) begin
          ext <= 1'b1;
        end else begin
          brk <= 1'b0;
          ext <= 1'b0;
          // An extended release never frees a normal key that shares its code.
          if (brk) begin
            if (!ext && key_code == held)
              held <= 8'h00;
          end else if (!ext && key_code != held) begin
            press_valid <= 1'b1;
            press_code  <= key_code;
            held        <= key_code;
          end
        end
      end
    end
  end

endmodule

// File: rtl/typing_checker.sv
// Game controller: matches filtered key presses to the expected character, tracks level/errors.
// get_next_character one cycle after the matching key_valid; inputs are strobes, no backpressure.
module typing_checker
  import typer_pkg::*;
#(
  parameter int         NUM_LEVELS    = 4,
  parameter logic [7:0] MAX_ERRORS    = 8'd16,
  parameter int         SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic       key_valid,
  input  logic [7:0] key_code,
  input  logic [7:0] comparison_data,
  input  logic [7:0] num_char,
  output logic       get_next_character,
  output logic       enable_next_level,
  output logic [7:0] char_index,
  output logic [7:0] error_count,
  output logic [3:0] level,
  output logic       playing,
  output logic       game_won,
  output logic       game_over
);

  localparam logic [3:0] LAST_LEVEL  = 4'(NUM_LEVELS - 1);
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  logic       press_valid;
  logic [7:0] press_code;

  ps2_make_filter u_filter (
    .clk         (clk),
    .resetn      (resetn),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .press_valid (press_valid),
    .press_code  (press_code)
  );

  state_t     state, state_n;
  logic [7:0] settle_cnt, settle_cnt_n;
  logic [7:0] char_index_n, error_count_n, err_inc;
  logic [3:0] level_n;
  logic       game_won_n, game_over_n, enable_n;
  logic [8:0] ci_plus;

  assign ci_plus = {1'b0, char_index} + 9'd1;
  assign err_inc = sat_inc8(error_count);
  assign playing = (state == ST_PLAY);

  always_comb begin
    state_n            = state;
    settle_cnt_n       = settle_cnt;
    char_index_n       = char_index;
    error_count_n      = error_count;
    level_n            = level;
    game_won_n         = game_won;
    game_over_n        = game_over;
    enable_n           = 1'b0;
    get_next_character = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          enable_n      = 1'b1;
          char_index_n  = 8'd0;
          error_count_n = 8'd0;
          level_n       = 4'd0;
          game_won_n    = 1'b0;
          game_over_n   = 1'b0;
          settle_cnt_n  = 8'd0;
          state_n       = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (settle_cnt == SETTLE_LAST) begin
          settle_cnt_n = 8'd0;
          state_n      = ST_PLAY;
        end else begin
          settle_cnt_n = settle_cnt + 8'd1;
        end
      end
      ST_PLAY: begin
        if (num_char == 8'd0) begin
          state_n = ST_NEXT;
        end else if (press_valid) begin
          if (press_code == comparison_data) begin
            get_next_character = 1'b1;
            char_index_n       = ci_plus[7:0];
            if (ci_plus == {1'b0, num_char})
              state_n = ST_NEXT;
          end else begin
            error_count_n = err_inc;
            if (err_inc >= MAX_ERRORS) begin
              game_over_n = 1'b1;
              state_n     = ST_DONE;
            end
          end
        end
      end
      ST_NEXT: begin
        if (level == LAST_LEVEL) begin
          game_won_n = 1'b1;
          state_n    = ST_DONE;
        end else begin
          enable_n     = 1'b1;
          level_n      = level + 4'd1;
          char_index_n = 8'd0;
          settle_cnt_n = 8'd0;
          state_n      = ST_SETTLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state             <= ST_IDLE;
      settle_cnt        <= 8'd0;
      char_index        <= 8'd0;
      error_count       <= 8'd0;
      level             <= 4'd0;
      game_won          <= 1'b0;
      game_over         <= 1'b0;
      enable_next_level <= 1'b0;
    end else begin
      state             <= state_n;
      settle_cnt        <= settle_cnt_n;
      char_index        <= char_index_n;
      error_count       <= error_count_n;
      level             <= level_n;
      game_won          <= game_won_n;
      game_over         <= game_over_n;
      enable_next_level <= enable_n;
    end
  end

endmodule
